// File: rtl/llr_sat_alu.sv
// Multi-lane saturating LLR unit: add, sub (b-a), min-sum f and pass per lane,
// behind a two-register valid/ready pipeline with a saturating clamp-event counter.
module llr_sat_alu #(
    parameter int WIDTH     = 6,
    parameter int LANES     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2*LANES-1:0]       in_op,
    input  logic [WIDTH*LANES-1:0]   in_a,
    input  logic [WIDTH*LANES-1:0]   in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH*LANES-1:0]   out_data,
    output logic [LANES-1:0]         out_sat,
    input  logic                     cnt_clr,
    output logic [CNT_WIDTH-1:0]     sat_cnt
);

    localparam int PC_W  = $clog2(LANES + 1);
    localparam int SUM_W = ((CNT_WIDTH > PC_W) ? CNT_WIDTH : PC_W) + 1;
    localparam logic signed [WIDTH:0] MAXW = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH:0] MINW = {2'b11, {(WIDTH-1){1'b0}}};
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_WIDTH){1'b0}}, {CNT_WIDTH{1'b1}}};

    // Returns {clamped_flag, value} for a WIDTH+1 bit intermediate.
    function automatic logic [WIDTH:0] clamp(input logic signed [WIDTH:0] x);
        if (x > MAXW)
            return {1'b1, MAXW[WIDTH-1:0]};
        else if (x < MINW)
            return {1'b1, MINW[WIDTH-1:0]};
        else
            return {1'b0, x[WIDTH-1:0]};
    endfunction

    function automatic logic signed [WIDTH:0] abs_sat(input logic signed [WIDTH:0] x);
        logic signed [WIDTH:0] m;
        m = x[WIDTH] ? -x : x;
        if (m > MAXW)
            m = MAXW;
        return m;
    endfunction

    function automatic logic [WIDTH:0] lane_op(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic signed [WIDTH:0] aw, bw, ma, mb, mag, neg;
        logic [WIDTH:0] r;
        r   = '0;
        aw  = {a[WIDTH-1], a};
        bw  = {b[WIDTH-1], b};
        ma  = abs_sat(aw);
        mb  = abs_sat(bw);
        mag = (ma < mb) ? ma : mb;
        neg = -mag;
        case (op)
            2'b00: r = clamp(aw + bw);
            2'b01: r = clamp(bw - aw);
            2'b10: begin
                // mag is never negative, so a zero result is always +0
                r[WIDTH-1:0] = (aw[WIDTH] ^ bw[WIDTH]) ? neg[WIDTH-1:0] : mag[WIDTH-1:0];
                r[WIDTH]     = (aw == MINW) && (bw == MINW);
            end
            default: r = {1'b0, a};
        endcase
        return r;
    endfunction

    logic                   en1, en2;
    logic                   vld_p1;
    logic [WIDTH*LANES-1:0] data_p1;
    logic [LANES-1:0]       sat_p1;
    logic [WIDTH*LANES-1:0] res_c;
    logic [LANES-1:0]       flg_c;
    logic [PC_W-1:0]        pc_c;
    logic [SUM_W-1:0]       sum_c;

    assign en2      = !out_valid | out_ready;
    assign en1      = !vld_p1 | en2;
    assign in_ready = en1 & !rst;

    always_comb begin
        res_c = '0;
        flg_c = '0;
        for (int i = 0; i < LANES; i++) begin
            {flg_c[i], res_c[WIDTH*i +: WIDTH]} =
                lane_op(in_op[2*i +: 2], in_a[WIDTH*i +: WIDTH], in_b[WIDTH*i +: WIDTH]);
        end
    end

    // S1: computed results
    always_ff @(posedge clk) begin
        if (rst)
            vld_p1 <= 1'b0;
        else if (en1)
            vld_p1 <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            data_p1 <= res_c;
            sat_p1  <= flg_c;
        end
    end

    // S2: output register
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= '0;
        end else if (en2) begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                out_data <= data_p1;
                out_sat  <= sat_p1;
            end
        end
    end

    always_comb begin
        pc_c = '0;
        for (int i = 0; i < LANES; i++)
            pc_c = pc_c + PC_W'(out_sat[i]);
        sum_c = SUM_W'(sat_cnt) + SUM_W'(pc_c);
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr)
            sat_cnt <= '0;
        else if (out_valid && out_ready)
            sat_cnt <= (sum_c > CNT_MAX) ? {CNT_WIDTH{1'b1}} : sum_c[CNT_WIDTH-1:0];
    end

endmodule

// File: tb/tb_llr_sat_alu.sv
// Directed and randomised checks of llr_sat_alu (WIDTH=6, LANES=4, CNT_WIDTH=3).
module tb_llr_sat_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_op;
    logic [23:0] in_a;
    logic [23:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic [3:0]  out_sat;
    logic        cnt_clr;
    logic [2:0]  sat_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [23:0] d;
        logic [3:0]  s;
        int          cyc;
    } beat_t;
    beat_t q[$];

    llr_sat_alu #(.WIDTH(6), .LANES(4), .CNT_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
        .cnt_clr(cnt_clr), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    function automatic logic [23:0] pk(input int v0, input int v1, input int v2, input int v3);
        return {6'(v3), 6'(v2), 6'(v1), 6'(v0)};
    endfunction

    function automatic logic [6:0] ref_lane(input logic [1:0] op, input logic [5:0] ar,
                                            input logic [5:0] br);
        int a, b, r, ma, mb;
        bit s;
        a = int'($signed(ar));
        b = int'($signed(br));
        s = 1'b0;
        r = 0;
        case (op)
            2'd0: r = a + b;
            2'd1: r = b - a;
            2'd2: begin
                ma = (a < 0) ? -a : a;
                mb = (b < 0) ? -b : b;
                if (ma > 31) ma = 31;
                if (mb > 31) mb = 31;
                r = (ma < mb) ? ma : mb;
                if ((a < 0) != (b < 0)) r = -r;
                s = (a == -32) && (b == -32);
            end
            default: r = a;
        endcase
        if (op < 2'd2) begin
            if (r > 31) begin r = 31; s = 1'b1; end
            else if (r < -32) begin r = -32; s = 1'b1; end
        end
        return {s, r[5:0]};
    endfunction

    function automatic logic [27:0] ref_beat(input logic [7:0] op, input logic [23:0] a,
                                             input logic [23:0] b);
        logic [23:0] d;
        logic [3:0]  s;
        logic [6:0]  t;
        for (int i = 0; i < 4; i++) begin
            t = ref_lane(op[2*i +: 2], a[6*i +: 6], b[6*i +: 6]);
            d[6*i +: 6] = t[5:0];
            s[i] = t[6];
        end
        return {s, d};
    endfunction

    task automatic single(input string tag, input logic [1:0] op, input int a, input int b,
                          input int exp_v, input logic exp_s);
        in_valid = 1'b1;
        in_op    = {6'b111111, op};
        in_a     = {18'd0, 6'(a)};
        in_b     = {18'd0, 6'(b)};
        step();
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
        step();
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, 32'($signed(out_data[5:0])), 32'(exp_v));
        chk({tag, "_sat"}, 32'(out_sat[0]), 32'(exp_s));
        step();
    endtask

    task automatic run(input int ncyc, input int vprob, input int rprob, input bit drain);
        logic [27:0] e;
        beat_t b;
        bit infire, outfire;
        for (int k = 0; k < ncyc; k++) begin
            if (drain && q.size() == 0 && !out_valid) break;
            in_valid  = ($urandom_range(99) < vprob);
            in_op     = 8'($urandom);
            in_a      = 24'($urandom);
            in_b      = 24'($urandom);
            out_ready = ($urandom_range(99) < rprob);
            #1;
            chk("in_ready", 32'(in_ready), 32'(!(q.size() == 2 && !out_ready)));
            if (rprob == 100)
                chk("out_valid_timing", 32'(out_valid), 32'(q.size() > 0 && q[0].cyc + 2 <= cyc));
            if (out_valid) begin
                if (q.size() == 0)
                    chk("out_valid_extra", 32'(out_valid), 32'd0);
                else begin
                    chk("stream_data", 32'(out_data), 32'(q[0].d));
                    chk("stream_sat", 32'(out_sat), 32'(q[0].s));
                end
            end
            infire  = in_valid && in_ready;
            outfire = out_valid && out_ready && (q.size() > 0);
            if (outfire) void'(q.pop_front());
            if (infire) begin
                e     = ref_beat(in_op, in_a, in_b);
                b.d   = e[23:0];
                b.s   = e[27:24];
                b.cyc = cyc;
                q.push_back(b);
            end
            step();
        end
        in_valid = 1'b0;
        if (drain) chk("drain_left", 32'(q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
        out_ready = 1'b1; cnt_clr = 1'b0;
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        single("add_pos", 2'b00, 20, 15, 31, 1'b1);
        single("add_neg", 2'b00, -20, -15, -32, 1'b1);
        single("add_mid", 2'b00, 10, -3, 7, 1'b0);
        single("sub_min", 2'b01, -32, 0, 31, 1'b1);
        single("sub_neg", 2'b01, 5, -30, -32, 1'b1);
        single("f_mix", 2'b10, -7, 12, -7, 1'b0);
        single("f_min", 2'b10, -32, -32, 31, 1'b1);
        single("pass_min", 2'b11, -32, 7, -32, 1'b0);

        run(100, 100, 100, 1'b0);
        run(50, 0, 100, 1'b1);
        run(300, 60, 50, 1'b0);
        run(50, 0, 100, 1'b1);

        // counter saturation with a 3-bit counter
        out_ready = 1'b1;
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("cnt_clr0", 32'(sat_cnt), 32'd0);
        in_valid = 1'b1;
        in_op    = 8'h00;
        in_a     = pk(20, 20, 20, 20);
        in_b     = pk(15, 15, 15, 15);
        step();
        step();
        step();
        chk("cnt_4", 32'(sat_cnt), 32'd4);
        step();
        in_valid = 1'b0;
        chk("cnt_7", 32'(sat_cnt), 32'd7);
        step();
        chk("cnt_hold7", 32'(sat_cnt), 32'd7);
        chk("cnt_last_valid", 32'(out_valid), 32'd1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("cnt_clr_prio", 32'(sat_cnt), 32'd0);
        chk("cnt_empty", 32'(out_valid), 32'd0);

        // reset while two beats are held under stall
        in_valid = 1'b1;
        in_op    = 8'h00;
        in_a     = pk(20, 20, 20, 20);
        in_b     = pk(15, 15, 15, 15);
        step();
        in_op    = 8'hff;
        in_a     = pk(5, -6, 7, -8);
        step();
        in_op    = 8'h00;
        in_a     = pk(1, 1, 1, 1);
        in_b     = pk(1, 1, 1, 1);
        step();
        chk("stall_cnt4", 32'(sat_cnt), 32'd4);
        out_ready = 1'b0;
        #1;
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        step();
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(pk(5, -6, 7, -8)));
        chk("stall_sat", 32'(out_sat), 32'd0);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_cycle_in_ready", 32'(in_ready), 32'd0);
        step();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_cnt", 32'(sat_cnt), 32'd0);
        rst = 1'b0;
        in_valid  = 1'b1;
        in_op     = 8'hff;
        in_a      = pk(1, 2, 3, 4);
        out_ready = 1'b1;
        #1;
        chk("after_rst_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("after_rst_lat1", 32'(out_valid), 32'd0);
        step();
        chk("after_rst_valid", 32'(out_valid), 32'd1);
        chk("after_rst_data", 32'(out_data), 32'(pk(1, 2, 3, 4)));
        step();
        chk("after_rst_empty", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
